// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU opcodes driven on
// the shared ALU port, MDU operation codes and the FSM state encoding.
package mdu_pkg;

   // ALU opcodes understood by the core's 32-bit ALU
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLTU = 4'b0110;

   // MDU operation select (2'b11 is reserved and returns 0)
   localparam logic [1:0] MDU_MUL  = 2'b00;
   localparam logic [1:0] MDU_DIVU = 2'b01;
   localparam logic [1:0] MDU_REMU = 2'b10;

   // Sequencer states
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DCMP = 3'd2;
   localparam logic [2:0] ST_DSUB = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer. Borrows the core's ALU one
// operation per cycle: shift-and-add for MUL (one cycle per bit) and
// restoring division (compare + subtract, two cycles per bit).
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_control,
   input  logic [XLEN-1:0] alu_result
);

   // acc_q: MUL accumulator / divide partial remainder
   // x_q:   MUL shifted multiplicand / divide quotient (dividend shifts out)
   // y_q:   MUL shifted multiplier  / divisor
   logic [2:0]      state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] x_q, x_d;
   logic [XLEN-1:0] y_q, y_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            ge_q, ge_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [XLEN-1:0] rs;
   logic            cy;
   logic [XLEN-1:0] acc_next;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;

   // Shifted partial remainder and the bit that falls off its top
   assign rs = {acc_q[XLEN-2:0], x_q[XLEN-1]};
   assign cy = acc_q[XLEN-1];

   // Next-state, datapath and ALU port control
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      x_d         = x_q;
      y_d         = y_q;
      cnt_d       = cnt_q;
      ge_d        = ge_q;
      result_d    = result_q;
      alu_a       = '0;
      alu_b       = '0;
      alu_control = ALU_ADD;
      acc_next    = acc_q;
      rem_next    = rs;
      quo_next    = {x_q[XLEN-2:0], ge_q};

      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               op_d  = op;
               acc_d = '0;
               x_d   = a;
               y_d   = b;
               cnt_d = '0;
               case (op)
                  MDU_MUL:            state_d = ST_MUL;
                  MDU_DIVU, MDU_REMU: state_d = ST_DCMP;
                  default: begin
                     // Reserved op: a single final MUL pass with a zero
                     // multiplier, so the result is 0 and done lands in cycle 2.
                     state_d = ST_MUL;
                     y_d     = '0;
                     cnt_d   = 5'd31;
                  end
               endcase
            end
         end
         ST_MUL: begin
            alu_a       = acc_q;
            alu_b       = x_q;
            alu_control = ALU_ADD;
            acc_next    = y_q[0] ? alu_result : acc_q;
            acc_d       = acc_next;
            x_d         = x_q << 1;
            y_d         = y_q >> 1;
            cnt_d       = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               result_d = acc_next;
               state_d  = ST_DONE;
            end
         end
         ST_DCMP: begin
            alu_a       = rs;
            alu_b       = y_q;
            alu_control = ALU_SLTU;
            // A carried-out top bit means rs exceeds any 32-bit divisor.
            ge_d        = cy | ~alu_result[0];
            state_d     = ST_DSUB;
         end
         ST_DSUB: begin
            alu_a       = rs;
            alu_b       = y_q;
            alu_control = ALU_SUB;
            rem_next    = ge_q ? alu_result : rs;
            acc_d       = rem_next;
            x_d         = quo_next;
            cnt_d       = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               result_d = (op_q == MDU_REMU) ? rem_next : quo_next;
               state_d  = ST_DONE;
            end else begin
               state_d  = ST_DCMP;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Abort wins over everything; the visible result is left untouched.
      if (flush && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= MDU_MUL;
         acc_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         cnt_q    <= '0;
         ge_q     <= 1'b0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         ge_q     <= ge_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with a behavioural ALU on its port.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_control;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   mdu_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result)
   );

   // Reference ALU: combinational from its operand/control port
   always_comb begin
      case (alu_control)
         ALU_ADD:  alu_result = alu_a + alu_b;
         ALU_SUB:  alu_result = alu_a - alu_b;
         ALU_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
         default:  alu_result = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
   endtask

   // Launch an op in cycle 0 (called #1 after a rising edge while idle),
   // optionally inject a stray start in inj_cyc, and check done cycle/result.
   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp_res,
                      input int exp_cyc, input int inj_cyc);
      int  cyc;
      bit  got;
      op = o; a = x; b = y; start = 1'b1;
      cyc = 0; got = 1'b0;
      @(posedge clk); #1; cyc = 1; start = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else begin
            @(posedge clk); #1; cyc++;
            start = (cyc == inj_cyc);
            if (cyc == inj_cyc) begin
               op = MDU_DIVU; a = 32'd100; b = 32'd3;
            end
         end
      end
      start = 1'b0;
      check({tag, " done seen"}, {31'd0, got}, 32'd1);
      check({tag, " done cycle"}, cyc, exp_cyc);
      check({tag, " result"}, result, exp_res);
      @(posedge clk); #1;
      check({tag, " idle after done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int  cyc;
      bit  saw_done;

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      #2;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset alu_control", {28'd0, alu_control}, {28'd0, ALU_ADD});
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      run("mul 7*6", MDU_MUL, 32'd7, 32'd6, 32'd42, 33, -1);
      run("mul ffff*ffff", MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, -1);
      run("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 65, -1);
      run("remu 100/7", MDU_REMU, 32'd100, 32'd7, 32'd2, 65, -1);
      run("divu 8000/1", MDU_DIVU, 32'h8000_0000, 32'd1, 32'h8000_0000, 65, -1);
      run("remu cy path", MDU_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 65, -1);
      run("divu by 0", MDU_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 65, -1);
      run("remu by 0", MDU_REMU, 32'h1234, 32'd0, 32'h1234, 65, -1);
      run("reserved op", 2'b11, 32'd9, 32'd9, 32'd0, 2, -1);
      run("mul stray start", MDU_MUL, 32'd7, 32'd6, 32'd42, 33, 5);

      // Flush a MUL in cycle 10: idle in cycle 11, no done, result kept (42)
      op = MDU_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
      saw_done = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         flush = (cyc == 10);
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (cyc == 10) check("flush busy in cycle 10", {31'd0, busy}, 32'd1);
         if (cyc == 11) check("flush busy in cycle 11", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
      end
      flush = 1'b0;
      check("flush no done", {31'd0, saw_done}, 32'd0);
      check("flush result kept", result, 32'd42);

      // Reset in cycle 20 of a DIVU (a DSUB cycle), then a fresh MUL
      op = MDU_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      check("divu cycle 20 drives SUB", {28'd0, alu_control}, {28'd0, ALU_SUB});
      rst = 1'b1; #1;
      check("mid reset busy", {31'd0, busy}, 32'd0);
      check("mid reset done", {31'd0, done}, 32'd0);
      check("mid reset result", result, 32'd0);
      check("mid reset alu_a", alu_a, 32'd0);
      check("mid reset alu_b", alu_b, 32'd0);
      check("mid reset alu_control", {28'd0, alu_control}, {28'd0, ALU_ADD});
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      run("mul 3*5 after reset", MDU_MUL, 32'd3, 32'd5, 32'd15, 33, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
